// File: rtl/iob_diff_sched_pkg.sv
// ----------------------------------------------------------------------------
// iob_diff_sched_pkg
//   Shared defaults and index helpers for the time-multiplexed differencer.
//   DEF_DATA_W / DEF_N_CH / DEF_RST_VAL are the parameter defaults of the top.
//   wrap_inc / wrap_add do modulo-N index arithmetic for non-power-of-two N.
// ----------------------------------------------------------------------------
package iob_diff_sched_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_N_CH    = 4;
    localparam int unsigned DEF_RST_VAL = 0;

    // (idx + 1) mod n, valid for idx < n
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 32'd0 : idx + 1;
    endfunction

    // (base + off) mod n, valid for base < n and off < n
    function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/iob_diff_sched_rr.sv
// ----------------------------------------------------------------------------
// iob_diff_sched_rr
//   Round-robin arbiter. Grants the first requester at or after the pointer,
//   wrapping modulo N_CH; the pointer moves to one past the granted channel.
//   Ports:
//     clk      clock
//     cke      clock enable; pointer holds when 0
//     rst      synchronous active-high reset, pointer -> 0
//     req      per-channel requests (already qualified by the caller)
//     gnt      one-hot grant (combinational from req)
//     gnt_idx  binary index of the granted channel
//     gnt_any  a grant is issued this cycle; also the pointer advance enable
// ----------------------------------------------------------------------------
module iob_diff_sched_rr
    import iob_diff_sched_pkg::*;
#(
    parameter int unsigned N_CH = DEF_N_CH,
    parameter int unsigned CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            cke,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [CH_W-1:0] ptr_q;
    logic [CH_W-1:0] scan_idx;

    // Scan from the pointer; the first hit wins.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        scan_idx = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            scan_idx = CH_W'(wrap_add(int'(ptr_q), i, N_CH));
            if (!gnt_any && req[scan_idx]) begin
                gnt[scan_idx] = 1'b1;
                gnt_idx       = scan_idx;
                gnt_any       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cke) begin
            if (rst) begin
                ptr_q <= '0;
            end else if (gnt_any) begin
                ptr_q <= CH_W'(wrap_inc(int'(gnt_idx), N_CH));
            end
        end
    end

endmodule

// File: rtl/iob_diff_sched.sv
// ----------------------------------------------------------------------------
// iob_diff_sched
//   One differencing datapath (out = sample - previous sample of the same
//   channel) shared by N_CH valid/ready requesters through a round-robin
//   scheduler. Per-channel history lives in a register bank; results leave
//   through a single registered output stage with backpressure.
//
//   Build option: define IOB_DIFF_SCHED_SAT_EN for a signed saturating
//   difference; otherwise the difference wraps modulo 2^DATA_W.
//
//   Ports:
//     clk_i        clock
//     cke_i        clock enable; all state holds and no grants when 0
//     rst_i        synchronous reset, active-high
//     req_valid_i  per-channel sample valid
//     req_data_i   samples, channel k at [k*DATA_W +: DATA_W]
//     req_ready_o  one-hot grant; sample accepted when valid & ready
//     clr_i        per-channel history clear (clear, then any same-cycle update)
//     out_valid_o  result valid
//     out_ready_i  consumer ready
//     out_ch_o     channel index of the result
//     out_data_o   difference
// ----------------------------------------------------------------------------
module iob_diff_sched
    import iob_diff_sched_pkg::*;
#(
    parameter int unsigned         DATA_W  = DEF_DATA_W,
    parameter int unsigned         N_CH    = DEF_N_CH,
    parameter logic [DATA_W-1:0]   RST_VAL = DATA_W'(DEF_RST_VAL)
) (
    input  logic                      clk_i,
    input  logic                      cke_i,
    input  logic                      rst_i,
    input  logic [N_CH-1:0]           req_valid_i,
    input  logic [N_CH*DATA_W-1:0]    req_data_i,
    output logic [N_CH-1:0]           req_ready_o,
    input  logic [N_CH-1:0]           clr_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [$clog2(N_CH)-1:0]   out_ch_o,
    output logic [DATA_W-1:0]         out_data_o
);

    localparam int unsigned CH_W = $clog2(N_CH);

    logic              stage_free;
    logic              grant_en;
    logic [N_CH-1:0]   req_masked;
    logic [N_CH-1:0]   gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;

    logic [DATA_W-1:0] hist_q [N_CH];
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] sel_prev;
    logic [DATA_W-1:0] diff;

    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [DATA_W-1:0] out_data_q;

    // ------------------------------------------------------------------
    // Scheduling: grants only when the output stage can take a result,
    // and never during reset or while the clock enable is low.
    // ------------------------------------------------------------------
    assign stage_free = ~out_valid_q | out_ready_i;
    assign grant_en   = cke_i & ~rst_i & stage_free;
    assign req_masked = req_valid_i & {N_CH{grant_en}};

    iob_diff_sched_rr #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_rr (
        .clk     (clk_i),
        .cke     (cke_i),
        .rst     (rst_i),
        .req     (req_masked),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign req_ready_o = gnt;

    // ------------------------------------------------------------------
    // Operand select. A same-cycle clear makes the granted channel see
    // RST_VAL as its previous sample.
    // ------------------------------------------------------------------
    always_comb begin
        sel_data = '0;
        sel_prev = RST_VAL;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt[k]) begin
                sel_data = req_data_i[k*DATA_W +: DATA_W];
                sel_prev = clr_i[k] ? RST_VAL : hist_q[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Difference
    // ------------------------------------------------------------------
`ifdef IOB_DIFF_SCHED_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] diff_ext;

    // One guard bit: the top two bits disagree exactly on signed overflow.
    always_comb begin
        diff_ext = {sel_data[DATA_W-1], sel_data} - {sel_prev[DATA_W-1], sel_prev};
        case (diff_ext[DATA_W -: 2])
            2'b01:   diff = SAT_MAX;
            2'b10:   diff = SAT_MIN;
            default: diff = diff_ext[DATA_W-1:0];
        endcase
    end
`else
    assign diff = sel_data - sel_prev;
`endif

    // ------------------------------------------------------------------
    // History bank: reset > accept > clear. Accept wins over clear because
    // the clear has already been applied to the operand above.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            for (int k = 0; k < N_CH; k++) begin
                if (rst_i) begin
                    hist_q[k] <= RST_VAL;
                end else if (gnt[k]) begin
                    hist_q[k] <= req_data_i[k*DATA_W +: DATA_W];
                end else if (clr_i[k]) begin
                    hist_q[k] <= RST_VAL;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage. A new accept reloads it even while draining, giving
    // one result per cycle; otherwise a drain just drops valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                out_valid_q <= 1'b0;
                out_ch_q    <= '0;
                out_data_q  <= '0;
            end else if (gnt_any) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= gnt_idx;
                out_data_q  <= diff;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_iob_diff_sched.sv
// ----------------------------------------------------------------------------
// tb_iob_diff_sched
//   Bench for iob_diff_sched with DATA_W=8, N_CH=3, RST_VAL=0.
//   Directed table, hand-written stall/clock-enable sequences, then random
//   traffic against a behavioural model. Honours IOB_DIFF_SCHED_SAT_EN.
// ----------------------------------------------------------------------------
module tb_iob_diff_sched;

    localparam int DW = 8;
    localparam int NC = 3;

`ifdef IOB_DIFF_SCHED_SAT_EN
    localparam logic [7:0] EXP_BIG_NEG = 8'h80;
    localparam bit         SAT         = 1'b1;
`else
    localparam logic [7:0] EXP_BIG_NEG = 8'h38;
    localparam bit         SAT         = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          cke;
    logic          rst;
    logic [2:0]    req_valid;
    logic [23:0]   req_data;
    logic [2:0]    req_ready;
    logic [2:0]    clr;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_ch;
    logic [7:0]    out_data;

    int n_vec = 0;
    int n_err = 0;

    iob_diff_sched #(
        .DATA_W  (DW),
        .N_CH    (NC),
        .RST_VAL (8'd0)
    ) dut (
        .clk_i       (clk),
        .cke_i       (cke),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .clr_i       (clr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_ch_o    (out_ch),
        .out_data_o  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [2:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [2:0] cl;
        logic [2:0] erdy;
        logic       eov;
        logic [1:0] ech;
        logic [7:0] ed;
        logic       pl;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [7:0] d2,
                                input logic [2:0] cl, input logic [2:0] erdy,
                                input logic eov, input logic [1:0] ech, input logic [7:0] ed,
                                input logic pl);
        vec_t t;
        t.r = r; t.v = v; t.d0 = d0; t.d1 = d1; t.d2 = d2; t.cl = cl;
        t.erdy = erdy; t.eov = eov; t.ech = ech; t.ed = ed; t.pl = pl;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, check ready before the rising
    // edge and the registered outputs just after it.
    task automatic step(input string name, input logic c, input logic r, input logic [2:0] v,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [2:0] cl, input logic ordy, input logic [2:0] erdy,
                        input logic eov, input logic [1:0] ech, input logic [7:0] ed,
                        input logic pl);
        @(negedge clk);
        cke       = c;
        rst       = r;
        req_valid = v;
        req_data  = {d2, d1, d0};
        clr       = cl;
        out_ready = ordy;
        #1;
        chk({name, " req_ready"}, 32'(req_ready), 32'(erdy));
        @(posedge clk);
        #1;
        chk({name, " out_valid"}, 32'(out_valid), 32'(eov));
        if (pl) begin
            chk({name, " out_ch"}, 32'(out_ch), 32'(ech));
            chk({name, " out_data"}, 32'(out_data), 32'(ed));
        end
    endtask

    // Reference difference from signed integers.
    function automatic int model_diff(input int sample, input int prev);
        int s;
        s = sample - prev;
        if (SAT) begin
            if (s > 127)  s = 127;
            if (s < -128) s = -128;
        end
        return s;
    endfunction

    // Behavioural model state
    int   m_ptr;
    int   m_hist [3];
    logic m_ov;
    int   m_ch;
    int   m_d;

    initial begin
        cke = 1'b1; rst = 1'b1; req_valid = '0; req_data = '0; clr = '0; out_ready = 1'b1;

        //           r     v       d0     d1     d2     cl      erdy    eov   ech   ed      pl
        tbl[0]  = mk(1'b1, 3'b000, 8'd0,  8'd0,  8'd0,  3'b000, 3'b000, 1'b0, 2'd0, 8'd0,   1'b1);
        tbl[1]  = mk(1'b0, 3'b001, 8'd10, 8'd0,  8'd0,  3'b000, 3'b001, 1'b1, 2'd0, 8'd10,  1'b1);
        tbl[2]  = mk(1'b0, 3'b001, 8'd15, 8'd0,  8'd0,  3'b000, 3'b001, 1'b1, 2'd0, 8'd5,   1'b1);
        tbl[3]  = mk(1'b0, 3'b000, 8'd0,  8'd0,  8'd0,  3'b000, 3'b000, 1'b0, 2'd0, 8'd0,   1'b0);
        tbl[4]  = mk(1'b1, 3'b000, 8'd0,  8'd0,  8'd0,  3'b000, 3'b000, 1'b0, 2'd0, 8'd0,   1'b1);
        tbl[5]  = mk(1'b0, 3'b111, 8'd1,  8'd2,  8'd3,  3'b000, 3'b001, 1'b1, 2'd0, 8'd1,   1'b1);
        tbl[6]  = mk(1'b0, 3'b111, 8'd11, 8'd12, 8'd13, 3'b000, 3'b010, 1'b1, 2'd1, 8'd12,  1'b1);
        tbl[7]  = mk(1'b0, 3'b111, 8'd21, 8'd22, 8'd23, 3'b000, 3'b100, 1'b1, 2'd2, 8'd23,  1'b1);
        tbl[8]  = mk(1'b0, 3'b111, 8'd31, 8'd32, 8'd33, 3'b000, 3'b001, 1'b1, 2'd0, 8'd30,  1'b1);
        tbl[9]  = mk(1'b0, 3'b000, 8'd0,  8'd0,  8'd0,  3'b000, 3'b000, 1'b0, 2'd0, 8'd0,   1'b0);
        tbl[10] = mk(1'b1, 3'b000, 8'd0,  8'd0,  8'd0,  3'b000, 3'b000, 1'b0, 2'd0, 8'd0,   1'b1);
        tbl[11] = mk(1'b0, 3'b100, 8'd0,  8'd0,  8'd100, 3'b000, 3'b100, 1'b1, 2'd2, 8'd100, 1'b1);
        tbl[12] = mk(1'b0, 3'b100, 8'd0,  8'd0,  8'h9C, 3'b000, 3'b100, 1'b1, 2'd2, EXP_BIG_NEG,
                     1'b1);
        tbl[13] = mk(1'b0, 3'b010, 8'd0,  8'd50, 8'd0,  3'b000, 3'b010, 1'b1, 2'd1, 8'd50,  1'b1);
        tbl[14] = mk(1'b0, 3'b010, 8'd0,  8'd20, 8'd0,  3'b010, 3'b010, 1'b1, 2'd1, 8'd20,  1'b1);
        tbl[15] = mk(1'b0, 3'b010, 8'd0,  8'd25, 8'd0,  3'b000, 3'b010, 1'b1, 2'd1, 8'd5,   1'b1);
        tbl[16] = mk(1'b1, 3'b111, 8'd7,  8'd8,  8'd9,  3'b000, 3'b000, 1'b0, 2'd0, 8'd0,   1'b1);
        tbl[17] = mk(1'b0, 3'b111, 8'd7,  8'd8,  8'd9,  3'b000, 3'b001, 1'b1, 2'd0, 8'd7,   1'b1);
        tbl[18] = mk(1'b0, 3'b000, 8'd0,  8'd0,  8'd0,  3'b000, 3'b000, 1'b0, 2'd0, 8'd0,   1'b0);

        for (int i = 0; i < 19; i++) begin
            step($sformatf("tbl[%0d]", i), 1'b1, tbl[i].r, tbl[i].v, tbl[i].d0, tbl[i].d1,
                 tbl[i].d2, tbl[i].cl, 1'b1, tbl[i].erdy, tbl[i].eov, tbl[i].ech, tbl[i].ed,
                 tbl[i].pl);
        end

        // Backpressure: pointer=1, hist = {7, 0, 0}. Result must hold, no grants.
        step("stall_setup", 1'b1, 1'b0, 3'b010, 8'd0, 8'd40, 8'd0, 3'b000, 1'b1,
             3'b010, 1'b1, 2'd1, 8'd40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1'b1, 1'b0, 3'b110, 8'd0, 8'd99, 8'd60, 3'b000, 1'b0,
                 3'b000, 1'b1, 2'd1, 8'd40, 1'b1);
        end
        step("stall_release", 1'b1, 1'b0, 3'b110, 8'd0, 8'd99, 8'd60, 3'b000, 1'b1,
             3'b100, 1'b1, 2'd2, 8'd60, 1'b1);
        step("after_stall", 1'b1, 1'b0, 3'b010, 8'd0, 8'd99, 8'd0, 3'b000, 1'b1,
             3'b010, 1'b1, 2'd1, 8'd59, 1'b1);
        // Clock enable low: everything frozen even though the consumer is ready.
        step("cke_off", 1'b0, 1'b0, 3'b111, 8'd1, 8'd2, 8'd3, 3'b000, 1'b1,
             3'b000, 1'b1, 2'd1, 8'd59, 1'b1);
        step("cke_drain", 1'b1, 1'b0, 3'b000, 8'd0, 8'd0, 8'd0, 3'b000, 1'b1,
             3'b000, 1'b0, 2'd0, 8'd0, 1'b0);
        // Pointer is 2: ch2 idle, so ch0 wins over ch1; 5 - 7 = -2.
        step("cke_ptr", 1'b1, 1'b0, 3'b011, 8'd5, 8'd6, 8'd0, 3'b000, 1'b1,
             3'b001, 1'b1, 2'd0, 8'hFE, 1'b1);

        // Random traffic against the model, starting from reset.
        m_ptr = 0; m_ov = 1'b0; m_ch = 0; m_d = 0;
        for (int k = 0; k < 3; k++) m_hist[k] = 0;
        step("rand_rst", 1'b1, 1'b1, 3'b000, 8'd0, 8'd0, 8'd0, 3'b000, 1'b1,
             3'b000, 1'b0, 2'd0, 8'd0, 1'b1);

        for (int n = 0; n < 600; n++) begin
            logic        c, r, ordy;
            logic [2:0]  v, cl, erdy;
            logic [23:0] d;
            int          g;
            int          samp [3];

            c    = ($urandom_range(15) != 0);
            r    = c && ($urandom_range(40) == 0);
            v    = 3'($urandom);
            d    = 24'($urandom);
            cl   = ($urandom_range(7) == 0) ? 3'($urandom) : 3'b000;
            ordy = ($urandom_range(3) != 0);
            for (int k = 0; k < 3; k++) samp[k] = int'($signed(d[k*8 +: 8]));

            g = -1;
            if (c && !r && (!m_ov || ordy)) begin
                for (int i = 0; i < 3; i++) begin
                    if (g < 0 && v[(m_ptr + i) % 3]) g = (m_ptr + i) % 3;
                end
            end
            erdy = '0;
            if (g >= 0) erdy[g] = 1'b1;

            if (c) begin
                if (r) begin
                    m_ptr = 0; m_ov = 1'b0; m_ch = 0; m_d = 0;
                    for (int k = 0; k < 3; k++) m_hist[k] = 0;
                end else begin
                    if (g >= 0) begin
                        m_d   = model_diff(samp[g], cl[g] ? 0 : m_hist[g]);
                        m_ch  = g;
                        m_ov  = 1'b1;
                        m_ptr = (g + 1) % 3;
                    end else if (ordy) begin
                        m_ov = 1'b0;
                    end
                    for (int k = 0; k < 3; k++) begin
                        if (g == k)     m_hist[k] = samp[k];
                        else if (cl[k]) m_hist[k] = 0;
                    end
                end
            end

            step("rand", c, r, v, d[7:0], d[15:8], d[23:16], cl, ordy, erdy, m_ov,
                 2'(m_ch), 8'(m_d), m_ov | (c & r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
